// File: rtl/ex_commit_stage.sv
// ---------------------------------------------------------------------------
// ex_commit_stage
//
// Commit stage that sits directly after the 16-bit ALU. It registers the ALU
// result, owns the architectural NZCV status register and checks a 4-bit
// condition code against NZCV. The outcome of that check gates write-back,
// flag updates and branch redirects. Results go to write-back through a
// valid/ready handshake, and a synchronous flush squashes the stage.
//
// Optional feature (macro EX_COMMIT_PERF_CNT_EN):
//   When the macro is defined, the stage gets two 32-bit wrapping
//   performance counters: retired_cnt and squashed_cnt.
//
// Ports:
//   clk, rst_n           rising-edge clock, async active-low reset
//   in_valid / in_ready  upstream handshake (in_ready is combinational)
//   alu_res, alu_flags   ALU result and flags {N,Z,C,V}
//   rd, reg_we           destination register and its write request
//   set_flags            instruction wants to update NZCV
//   cond                 condition code, evaluated on the current NZCV
//   is_branch, branch_target  branch request and destination
//   flush                synchronous squash (highest priority after reset)
//   out_valid / out_ready downstream handshake
//   out_res, out_rd, out_we   registered write-back beat
//   nzcv                 architectural status register
//   branch_taken, branch_pc   one-cycle redirect pulse and its target
//   retired_cnt, squashed_cnt (EX_COMMIT_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module ex_commit_stage #(
    parameter int N  = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  alu_res,
    input  logic [3:0]    alu_flags,
    input  logic [RW-1:0] rd,
    input  logic          reg_we,
    input  logic          set_flags,
    input  logic [3:0]    cond,
    input  logic          is_branch,
    input  logic [N-1:0]  branch_target,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_res,
    output logic [RW-1:0] out_rd,
    output logic          out_we,
    output logic [3:0]    nzcv,
    output logic          branch_taken,
    output logic [N-1:0]  branch_pc
`ifdef EX_COMMIT_PERF_CNT_EN
    ,
    output logic [31:0]   retired_cnt,
    output logic [31:0]   squashed_cnt
`endif
);

    // Evaluate a condition code against the flags {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] f, input logic [3:0] c);
        logic n_f;
        logic z_f;
        logic c_f;
        logic v_f;
        logic res;
        n_f = f[3];
        z_f = f[2];
        c_f = f[1];
        v_f = f[0];
        case (c)
            4'd0:    res = z_f;
            4'd1:    res = ~z_f;
            4'd2:    res = c_f;
            4'd3:    res = ~c_f;
            4'd4:    res = n_f;
            4'd5:    res = ~n_f;
            4'd6:    res = v_f;
            4'd7:    res = ~v_f;
            4'd8:    res = c_f & ~z_f;
            4'd9:    res = ~c_f | z_f;
            4'd10:   res = (n_f == v_f);
            4'd11:   res = (n_f != v_f);
            4'd12:   res = ~z_f & (n_f == v_f);
            4'd13:   res = z_f | (n_f != v_f);
            4'd14:   res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic          out_valid_r;
    logic [N-1:0]  out_res_r;
    logic [RW-1:0] out_rd_r;
    logic          out_we_r;
    logic [3:0]    nzcv_r;
    logic          branch_taken_r;
    logic [N-1:0]  branch_pc_r;

    logic          in_ready_s;
    logic          accept_s;
    logic          pass_s;

    // Handshake and condition evaluation. The check uses the committed NZCV,
    // so an instruction accepted in the cycle right after a flag-setting one
    // already sees the new flags.
    always_comb begin
        in_ready_s = ~out_valid_r | out_ready;
        accept_s   = in_valid & in_ready_s & ~flush;
        pass_s     = cond_pass(nzcv_r, cond);
    end

    // Output beat, status register and branch pulse. During a stall the beat
    // holds because accept_s stays low. branch_taken is cleared by default,
    // so it lasts one cycle even while the beat itself is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r    <= 1'b0;
            out_res_r      <= {N{1'b0}};
            out_rd_r       <= {RW{1'b0}};
            out_we_r       <= 1'b0;
            nzcv_r         <= 4'b0000;
            branch_taken_r <= 1'b0;
            branch_pc_r    <= {N{1'b0}};
        end else if (flush) begin
            out_valid_r    <= 1'b0;
            out_we_r       <= 1'b0;
            branch_taken_r <= 1'b0;
        end else begin
            branch_taken_r <= 1'b0;
            if (accept_s) begin
                out_valid_r <= 1'b1;
                out_res_r   <= alu_res;
                out_rd_r    <= rd;
                out_we_r    <= reg_we & pass_s;
                if (set_flags & pass_s) begin
                    nzcv_r <= alu_flags;
                end
                if (is_branch & pass_s) begin
                    branch_taken_r <= 1'b1;
                    branch_pc_r    <= branch_target;
                end
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

`ifdef EX_COMMIT_PERF_CNT_EN
    logic [31:0] retired_cnt_r;
    logic [31:0] squashed_cnt_r;

    // Count accepted beats by condition outcome. Flushed beats are never
    // accepted, so neither counter sees them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt_r  <= 32'd0;
            squashed_cnt_r <= 32'd0;
        end else if (accept_s) begin
            if (pass_s) begin
                retired_cnt_r <= retired_cnt_r + 32'd1;
            end else begin
                squashed_cnt_r <= squashed_cnt_r + 32'd1;
            end
        end
    end

    assign retired_cnt  = retired_cnt_r;
    assign squashed_cnt = squashed_cnt_r;
`endif

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_r;
    assign out_res      = out_res_r;
    assign out_rd       = out_rd_r;
    assign out_we       = out_we_r;
    assign nzcv         = nzcv_r;
    assign branch_taken = branch_taken_r;
    assign branch_pc    = branch_pc_r;

endmodule

// File: doc/ex_commit_stage.md
Name: ex_commit_stage

Overview:
- Pipeline stage directly downstream of the 16-bit ALU.
- Each cycle it registers the ALU result and its 4-bit flags (3=N, 2=Z, 1=C, 0=V).
- Holds the architectural NZCV status register and evaluates a 4-bit condition code against it. This decides conditional write-back and branch resolution.
- Provides a valid/ready handshake to the write-back stage, plus a synchronous flush.

Parameters:
- N, 16, data/result/PC width (matches ALU width).
- RW, 4, destination register index width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- alu_res  input  N  ALU result.
- alu_flags  input  4  ALU flags {N,Z,C,V}.
- rd  input  RW  destination register.
- reg_we  input  1  instruction writes rd.
- set_flags  input  1  instruction updates NZCV.
- cond  input  4  condition code.
- is_branch  input  1  instruction is a branch.
- branch_target  input  N  branch destination.
- flush  input  1  synchronous squash of the stage.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_res  output  N  registered result.
- out_rd  output  RW  registered destination.
- out_we  output  1  write-back enable (0 if condition failed).
- nzcv  output  4  architectural status register.
- branch_taken  output  1  one-cycle redirect pulse.
- branch_pc  output  N  redirect target, valid while branch_taken = 1.

Behaviour:
- Reset (async, rst_n = 0): out_valid, out_res, out_rd, out_we, nzcv, branch_taken and branch_pc are all 0.
- Ready and accept:
  - in_ready = ~out_valid | out_ready (combinational).
  - accept = in_valid & in_ready & ~flush.
- Condition pass (combinational, evaluated on the current nzcv register):
  - 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V.
  - 8 HI C&~Z; 9 LS ~C|Z; 10 GE N==V; 11 LT N!=V; 12 GT ~Z&(N==V); 13 LE Z|(N!=V).
  - 14 AL 1; 15 NV 0.
- On accept (latency 1 cycle):
  - out_valid <= 1; out_res <= alu_res; out_rd <= rd.
  - out_we <= reg_we & pass.
  - If set_flags & pass: nzcv <= alu_flags.
  - If is_branch & pass: branch_taken <= 1 and branch_pc <= branch_target.
- A failed condition still produces a valid beat, with out_we = 0, nzcv unchanged and no branch.
- No accept, with out_valid & out_ready: out_valid <= 0.
- Output stall (out_valid & ~out_ready): out_res, out_rd and out_we hold; in_ready = 0.
- branch_taken:
  - Asserted exactly one cycle per taken branch, even if the output beat is stalled.
  - Cleared every cycle it was not set by an accept.
  - branch_pc holds its value otherwise.
- Back-to-back flags: the instruction accepted in cycle t+1 sees the nzcv written in cycle t. No extra bubble.
- Flush (synchronous, highest priority after reset):
  - out_valid <= 0, out_we <= 0, branch_taken <= 0.
  - Any beat presented that cycle is dropped: no nzcv update, no branch.
  - nzcv keeps its committed value.
- Reset mid-stall drops the held beat and returns all outputs to 0.

Optional Feature:
- Macro: EX_COMMIT_PERF_CNT_EN.
- Defined: adds two outputs, retired_cnt [31:0] and squashed_cnt [31:0], both reset to 0.
  - retired_cnt increments on each accept with pass = 1.
  - squashed_cnt increments on each accept with pass = 0.
  - Both wrap at 2^32.
  - Flushed beats count in neither.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst_n = 0 mid-stall with nzcv = 4'b1010 -> all outputs 0 asynchronously, and in_ready = 1 after release.
- Flag update then condition:
  - Beat 1: alu_res = 16'h0000, flags 4'b0100, set_flags = 1, cond = AL.
  - Beat 2 (next cycle): reg_we = 1, cond = EQ, rd = 3.
  - Expected: nzcv = 4'b0100, beat 2 out_we = 1, out_rd = 3.
- Condition fail: nzcv = 4'b0000, cond = EQ, reg_we = 1, set_flags = 1, flags 4'b1000 -> out_valid = 1, out_we = 0, nzcv stays 4'b0000.
- Branch:
  - nzcv = 4'b1001 (N = V), cond = GE, is_branch = 1, target 16'h0040 -> branch_taken high exactly 1 cycle with branch_pc = 16'h0040.
  - Same beat with cond = LT -> branch_taken stays 0.
- Backpressure: out_ready = 0 for 3 cycles with alu_res = 16'h1234 -> in_ready = 0 and out_res holds 16'h1234; the next beat is accepted in the cycle out_ready returns to 1.
- Flush: flush = 1 with in_valid = 1, set_flags = 1, flags 4'b0010 -> out_valid = 0 next cycle, nzcv unchanged, and (with EX_COMMIT_PERF_CNT_EN) both counters unchanged.
